// File: rtl/sr04_multi_ranger.sv
// sr04_multi_ranger
//   Round-robin controller for N_CH HC-SR04 ultrasonic rangers. Only one ping
//   is in flight at a time, so neighbouring sensors cannot hear each other's
//   bursts. Each channel gets echo timeout detection, a saturating cm
//   conversion, first-order IIR smoothing and near/far window flags.
//   motor_off is the OR of every channel's near, far and timeout flags. It
//   drives the fan motor control logic.
//
// Ports
//   clk           system clock
//   reset_n       asynchronous active-low reset
//   echo          raw echo pins, asynchronous to clk
//   trigger       trigger pins, at most one bit high at a time
//   distance      filtered distance in cm, channel k at [k*DIST_W +: DIST_W]
//   sample_valid  one-cycle pulse when a channel result is updated
//   sample_ch     channel of the current sample_valid; holds otherwise
//   timeout       per-channel sticky flag: that channel's last ping timed out
//   near, far     per-channel window flags, registered after sample_valid
//   motor_off     OR over all channels of (near | far | timeout)
module sr04_multi_ranger #(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned N_CH       = 2,
    parameter int unsigned DIST_W     = 12,
    parameter int unsigned TRIG_US    = 10,
    parameter int unsigned GAP_US     = 60_000,
    parameter int unsigned TIMEOUT_US = 30_000,
    parameter int unsigned US_PER_CM  = 58,
    parameter int unsigned AVG_SH     = 2,
    parameter int unsigned NEAR_CM    = 7,
    parameter int unsigned FAR_CM     = 80
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [N_CH-1:0]          echo,
    output logic [N_CH-1:0]          trigger,
    output logic [N_CH*DIST_W-1:0]   distance,
    output logic                     sample_valid,
    output logic [2:0]               sample_ch,
    output logic [N_CH-1:0]          timeout,
    output logic [N_CH-1:0]          near,
    output logic [N_CH-1:0]          far,
    output logic                     motor_off
);

    localparam int unsigned DIV     = CLK_HZ / 1_000_000;
    localparam int unsigned DIV_W   = $clog2(DIV);
    localparam int unsigned TMR_MAX = (GAP_US > TIMEOUT_US) ?
                                      ((GAP_US > TRIG_US) ? GAP_US : TRIG_US) :
                                      ((TIMEOUT_US > TRIG_US) ? TIMEOUT_US : TRIG_US);
    localparam int unsigned TMR_W   = ($clog2(TMR_MAX) < 1) ? 1 : $clog2(TMR_MAX);
    localparam int unsigned SUB_W   = ($clog2(US_PER_CM) < 1) ? 1 : $clog2(US_PER_CM);
    localparam int unsigned PTR_W   = (N_CH > 1) ? $clog2(N_CH) : 1;

    localparam logic [DIST_W-1:0] DMAX = {DIST_W{1'b1}};

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_TRIG = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_MEAS = 3'd3;
    localparam logic [2:0] S_UPD  = 3'd4;
    localparam logic [2:0] S_TMO  = 3'd5;
    localparam logic [2:0] S_NEXT = 3'd6;

    // ---------------- microsecond tick ----------------
    logic [DIV_W-1:0] div_q;
    logic             tick;

    assign tick = (div_q == DIV_W'(DIV - 1));

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge value of the others; blocking here would create ordering races.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) div_q <= '0;
        else          div_q <= tick ? '0 : div_q + 1'b1;
    end

    // ---------------- echo synchroniser and edge detect ----------------
    logic [N_CH-1:0] s1_q, s2_q, s3_q;
    logic [N_CH-1:0] rise, fall;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s1_q <= echo;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise = s2_q & ~s3_q;
    assign fall = ~s2_q & s3_q;

    // ---------------- ping sequencer ----------------
    logic [2:0]        state_q, state_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [SUB_W-1:0]  sub_q, sub_d;
    logic [DIST_W-1:0] raw_q, raw_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;

    logic [DIST_W-1:0] dist_q [N_CH];
    logic [N_CH-1:0]   primed_q, timeout_q;
    logic [N_CH-1:0]   trig_q, trig_d;

    // Per-channel selection by compare loop so any N_CH indexes cleanly.
    logic              rise_sel, fall_sel, primed_sel;
    logic [DIST_W-1:0] avg_sel;

    always_comb begin
        rise_sel   = 1'b0;
        fall_sel   = 1'b0;
        primed_sel = 1'b0;
        avg_sel    = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (ptr_q == PTR_W'(k)) begin
                rise_sel   = rise[k];
                fall_sel   = fall[k];
                primed_sel = primed_q[k];
                avg_sel    = dist_q[k];
            end
        end
    end

    // NOTE: every always_comb output gets a default first; a path that leaves
    // one unassigned would infer a latch.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        sub_d   = sub_q;
        raw_d   = raw_q;
        ptr_d   = ptr_q;
        case (state_q)
            S_IDLE: if (tick) begin
                if (tmr_q == TMR_W'(GAP_US - 1)) begin
                    tmr_d   = '0;
                    state_d = S_TRIG;
                end else tmr_d = tmr_q + 1'b1;
            end
            S_TRIG: if (tick) begin
                if (tmr_q == TMR_W'(TRIG_US - 1)) begin
                    tmr_d   = '0;
                    state_d = S_WAIT;
                end else tmr_d = tmr_q + 1'b1;
            end
            S_WAIT: begin
                if (rise_sel) begin
                    tmr_d   = '0;
                    sub_d   = '0;
                    raw_d   = '0;
                    state_d = S_MEAS;
                end else if (tick) begin
                    if (tmr_q == TMR_W'(TIMEOUT_US - 1)) state_d = S_TMO;
                    else                                 tmr_d   = tmr_q + 1'b1;
                end
            end
            S_MEAS: begin
                // The cm count also advances in the fall cycle. The counted
                // window is then exactly the echo width in clocks, so the
                // tick count is independent of the divider phase.
                if (tick) begin
                    if (sub_q == SUB_W'(US_PER_CM - 1)) begin
                        sub_d = '0;
                        if (raw_q != DMAX) raw_d = raw_q + 1'b1;
                    end else sub_d = sub_q + 1'b1;
                end
                if (fall_sel) state_d = S_UPD;
                else if (tick) begin
                    if (tmr_q == TMR_W'(TIMEOUT_US - 1)) state_d = S_TMO;
                    else                                 tmr_d   = tmr_q + 1'b1;
                end
            end
            S_UPD:  state_d = S_NEXT;
            S_TMO:  state_d = S_NEXT;
            S_NEXT: begin
                ptr_d   = (ptr_q == PTR_W'(N_CH - 1)) ? '0 : ptr_q + 1'b1;
                tmr_d   = '0;
                sub_d   = '0;
                raw_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Trigger is registered from next-state so the pin is glitch-free and
    // is high for exactly the TRIG dwell.
    always_comb begin
        trig_d = '0;
        for (int k = 0; k < N_CH; k++)
            trig_d[k] = (state_d == S_TRIG) && (ptr_d == PTR_W'(k));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            tmr_q   <= '0;
            sub_q   <= '0;
            raw_q   <= '0;
            ptr_q   <= '0;
            trig_q  <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            sub_q   <= sub_d;
            raw_q   <= raw_d;
            ptr_q   <= ptr_d;
            trig_q  <= trig_d;
        end
    end

    // ---------------- IIR filter ----------------
    logic signed [DIST_W:0]   diff, step;
    logic signed [DIST_W+1:0] sum;
    logic [DIST_W-1:0]        filt, new_avg;

    always_comb begin
        diff = $signed({1'b0, raw_q}) - $signed({1'b0, avg_sel});
        step = diff >>> AVG_SH;
        sum  = $signed({2'b00, avg_sel}) + $signed({step[DIST_W], step});
        if (sum[DIST_W+1])   filt = '0;
        else if (sum[DIST_W]) filt = DMAX;
        else                  filt = sum[DIST_W-1:0];
        new_avg = primed_sel ? filt : raw_q;
    end

    // ---------------- per-channel results ----------------
    logic       sample_valid_q;
    logic [2:0] sample_ch_q;

    // NOTE: the distance registers are few and drive outputs that must read 0
    // in reset, so they are reset; a large storage array would not be.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < N_CH; k++) dist_q[k] <= '0;
            primed_q       <= '0;
            timeout_q      <= '0;
            sample_valid_q <= 1'b0;
            sample_ch_q    <= '0;
        end else begin
            sample_valid_q <= (state_q == S_UPD) || (state_q == S_TMO);
            if ((state_q == S_UPD) || (state_q == S_TMO)) sample_ch_q <= 3'(ptr_q);
            for (int k = 0; k < N_CH; k++) begin
                if (ptr_q == PTR_W'(k)) begin
                    if (state_q == S_UPD) begin
                        dist_q[k]    <= new_avg;
                        primed_q[k]  <= 1'b1;
                        timeout_q[k] <= 1'b0;
                    end else if (state_q == S_TMO) begin
                        timeout_q[k] <= 1'b1;
                    end
                end
            end
        end
    end

    // ---------------- window flags ----------------
    // A channel that has never produced a result has no meaningful distance,
    // so its window flags stay low until it is primed.
    logic [N_CH-1:0] near_d, far_d, near_q, far_q;
    logic            motor_off_q;

    always_comb begin
        near_d = '0;
        far_d  = '0;
        for (int k = 0; k < N_CH; k++) begin
            near_d[k] = primed_q[k] && !timeout_q[k] && (dist_q[k] <= DIST_W'(NEAR_CM));
            far_d[k]  = primed_q[k] && !timeout_q[k] && (dist_q[k] >= DIST_W'(FAR_CM));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            near_q      <= '0;
            far_q       <= '0;
            motor_off_q <= 1'b0;
        end else begin
            near_q      <= near_d;
            far_q       <= far_d;
            motor_off_q <= |(near_d | far_d | timeout_q);
        end
    end

    always_comb begin
        distance = '0;
        for (int k = 0; k < N_CH; k++) distance[k*DIST_W +: DIST_W] = dist_q[k];
    end

    assign trigger      = trig_q;
    assign sample_valid = sample_valid_q;
    assign sample_ch    = sample_ch_q;
    assign timeout      = timeout_q;
    assign near         = near_q;
    assign far          = far_q;
    assign motor_off    = motor_off_q;

endmodule

// File: tb/tb_sr04_multi_ranger.sv
// tb_sr04_multi_ranger
//   Directed bench with three DUT instances at 2 MHz (2 clocks per us):
//     a: two channels, no filtering, 3000 us timeout
//     b: one channel, AVG_SH=2, 6000 us timeout
//     c: one channel, DIST_W=6, FAR_CM=40, 6000 us timeout
//   Only the instance chosen by sel sees echo stimulus. The others are held
//   in reset until their turn.
module tb_sr04_multi_ranger;

    localparam int DIV = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b, rst_c;
    logic echo_drv;
    int   echo_ch;
    int   sel;

    logic [1:0]  echo_a;
    logic        echo_b, echo_c;
    assign echo_a = (sel == 0 && echo_drv) ? (2'b01 << echo_ch) : 2'b00;
    assign echo_b = (sel == 1) && echo_drv;
    assign echo_c = (sel == 2) && echo_drv;

    logic [1:0]  trig_a, tmo_a, near_a, far_a;
    logic [23:0] dist_a;
    logic        sv_a, mo_a;
    logic [2:0]  sch_a;

    logic        trig_b, tmo_b, near_b, far_b, sv_b, mo_b;
    logic [11:0] dist_b;
    logic [2:0]  sch_b;

    logic        trig_c, tmo_c, near_c, far_c, sv_c, mo_c;
    logic [5:0]  dist_c;
    logic [2:0]  sch_c;

    sr04_multi_ranger #(
        .CLK_HZ(2_000_000), .N_CH(2), .DIST_W(12), .TRIG_US(10), .GAP_US(50),
        .TIMEOUT_US(3000), .US_PER_CM(58), .AVG_SH(0), .NEAR_CM(7), .FAR_CM(80)
    ) u_a (
        .clk(clk), .reset_n(rst_a), .echo(echo_a), .trigger(trig_a),
        .distance(dist_a), .sample_valid(sv_a), .sample_ch(sch_a),
        .timeout(tmo_a), .near(near_a), .far(far_a), .motor_off(mo_a)
    );

    sr04_multi_ranger #(
        .CLK_HZ(2_000_000), .N_CH(1), .DIST_W(12), .TRIG_US(10), .GAP_US(50),
        .TIMEOUT_US(6000), .US_PER_CM(58), .AVG_SH(2), .NEAR_CM(7), .FAR_CM(80)
    ) u_b (
        .clk(clk), .reset_n(rst_b), .echo(echo_b), .trigger(trig_b),
        .distance(dist_b), .sample_valid(sv_b), .sample_ch(sch_b),
        .timeout(tmo_b), .near(near_b), .far(far_b), .motor_off(mo_b)
    );

    sr04_multi_ranger #(
        .CLK_HZ(2_000_000), .N_CH(1), .DIST_W(6), .TRIG_US(10), .GAP_US(50),
        .TIMEOUT_US(6000), .US_PER_CM(58), .AVG_SH(0), .NEAR_CM(7), .FAR_CM(40)
    ) u_c (
        .clk(clk), .reset_n(rst_c), .echo(echo_c), .trigger(trig_c),
        .distance(dist_c), .sample_valid(sv_c), .sample_ch(sch_c),
        .timeout(tmo_c), .near(near_c), .far(far_c), .motor_off(mo_c)
    );

    // Observation view of the selected instance.
    logic [1:0]  trig_o, tmo_o, near_o, far_o;
    logic        sv_o, mo_o;
    logic [2:0]  sch_o;
    logic [11:0] d0_o, d1_o;

    always_comb begin
        trig_o = '0; tmo_o = '0; near_o = '0; far_o = '0;
        sv_o = 1'b0; mo_o = 1'b0; sch_o = '0; d0_o = '0; d1_o = '0;
        case (sel)
            0: begin
                trig_o = trig_a; tmo_o = tmo_a; near_o = near_a; far_o = far_a;
                sv_o = sv_a; mo_o = mo_a; sch_o = sch_a;
                d0_o = dist_a[11:0]; d1_o = dist_a[23:12];
            end
            1: begin
                trig_o = {1'b0, trig_b}; tmo_o = {1'b0, tmo_b};
                near_o = {1'b0, near_b}; far_o = {1'b0, far_b};
                sv_o = sv_b; mo_o = mo_b; sch_o = sch_b; d0_o = dist_b;
            end
            default: begin
                trig_o = {1'b0, trig_c}; tmo_o = {1'b0, tmo_c};
                near_o = {1'b0, near_c}; far_o = {1'b0, far_c};
                sv_o = sv_c; mo_o = mo_c; sch_o = sch_c; d0_o = {6'd0, dist_c};
            end
        endcase
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_trig"}, 32'(trig_o), 0);
        check({tag, "_d0"},   32'(d0_o),   0);
        check({tag, "_d1"},   32'(d1_o),   0);
        check({tag, "_sv"},   32'(sv_o),   0);
        check({tag, "_tmo"},  32'(tmo_o),  0);
        check({tag, "_near"}, 32'(near_o), 0);
        check({tag, "_far"},  32'(far_o),  0);
        check({tag, "_mo"},   32'(mo_o),   0);
    endtask

    // Wait for trigger[ch]; optionally raise echo while trigger is still high.
    task automatic wait_trig(input int ch, input bit raise);
        bit seen = 1'b0;
        int hi   = 0;
        echo_ch = ch;
        for (int n = 0; n < 4000 && !seen; n++) begin
            @(negedge clk);
            if (trig_o[ch]) seen = 1'b1;
        end
        check("trig_seen", 32'(seen), 1);
        if (seen) begin
            check("trig_onehot", 32'(trig_o), 32'(2'b01 << ch));
            if (raise) echo_drv = 1'b1;
            hi = 1;
            for (int n = 0; n < 1000 && trig_o[ch]; n++) begin
                @(negedge clk);
                if (trig_o[ch]) hi++;
            end
            check("trig_width", 32'(hi), 32'(10 * DIV));
        end
    endtask

    task automatic pulse_echo(input int us);
        @(posedge clk);
        #1 echo_drv = 1'b1;
        repeat (us * DIV) @(posedge clk);
        #1 echo_drv = 1'b0;
    endtask

    // Wait for sample_valid, check its channel and width, and return one
    // negedge later so the registered flags are already current.
    task automatic wait_sample(input int ch);
        bit seen = 1'b0;
        for (int n = 0; n < 15000 && !seen; n++) begin
            @(negedge clk);
            if (sv_o) seen = 1'b1;
        end
        check("sample_seen", 32'(seen), 1);
        check("sample_ch", 32'(sch_o), 32'(ch));
        @(negedge clk);
        check("sample_pulse", 32'(sv_o), 0);
    endtask

    task automatic ping(input int ch, input int us);
        wait_trig(ch, 1'b0);
        pulse_echo(us);
        wait_sample(ch);
    endtask

    initial begin
        sel = 0; echo_drv = 1'b0; echo_ch = 0;
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("rst");
        @(posedge clk); #1 rst_a = 1'b1;

        // 1160 us -> 20 cm, inside the window
        ping(0, 1160);
        check("p1_d0", 32'(d0_o), 20);
        check("p1_near", 32'(near_o), 0);
        check("p1_far", 32'(far_o), 0);
        check("p1_tmo", 32'(tmo_o), 0);
        check("p1_mo", 32'(mo_o), 0);

        // 1740 us -> 30 cm on ch1
        ping(1, 1740);
        check("p2_d1", 32'(d1_o), 30);
        check("p2_mo", 32'(mo_o), 0);

        ping(0, 1160);
        check("p3_d0", 32'(d0_o), 20);

        // ch1 never answers: timeout, distance held
        wait_trig(1, 1'b0);
        wait_sample(1);
        check("p4_tmo", 32'(tmo_o), 2);
        check("p4_d1", 32'(d1_o), 30);
        check("p4_near", 32'(near_o), 0);
        check("p4_far", 32'(far_o), 0);
        check("p4_mo", 32'(mo_o), 1);

        // 290 us -> 5 cm, near
        ping(0, 290);
        check("p5_d0", 32'(d0_o), 5);
        check("p5_near", 32'(near_o), 1);
        check("p5_tmo", 32'(tmo_o), 2);
        check("p5_mo", 32'(mo_o), 1);

        // good ping on ch1 clears its timeout
        ping(1, 1740);
        check("p6_tmo", 32'(tmo_o), 0);
        check("p6_d1", 32'(d1_o), 30);
        check("p6_mo", 32'(mo_o), 1);

        // ch0 echo already high before WAIT_RISE: no rise, timeout
        wait_trig(0, 1'b1);
        wait_sample(0);
        echo_drv = 1'b0;
        check("p7_tmo", 32'(tmo_o), 1);
        check("p7_d0", 32'(d0_o), 5);
        check("p7_near", 32'(near_o), 0);
        check("p7_mo", 32'(mo_o), 1);

        // sequencing continues on ch1
        ping(1, 1160);
        check("p8_d1", 32'(d1_o), 20);
        check("p8_tmo", 32'(tmo_o), 1);

        // reset in the middle of a measurement
        wait_trig(0, 1'b0);
        @(posedge clk); #1 echo_drv = 1'b1;
        repeat (400) @(posedge clk);
        @(negedge clk); #2 rst_a = 1'b0;
        #1 check_zero("rst_mid");
        echo_drv = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_a = 1'b1;
        ping(0, 1160);
        check("p10_d0", 32'(d0_o), 20);
        check("p10_d1", 32'(d1_o), 0);
        check("p10_tmo", 32'(tmo_o), 0);

        // filtered instance: 100 then 20 -> 100, 80
        sel = 1;
        @(posedge clk); #1 rst_b = 1'b1;
        ping(0, 5800);
        check("b1_d0", 32'(d0_o), 100);
        check("b1_far", 32'(far_o), 1);
        check("b1_mo", 32'(mo_o), 1);
        ping(0, 1160);
        check("b2_d0", 32'(d0_o), 80);
        check("b2_far", 32'(far_o), 1);
        // after reset the first sample loads unfiltered
        @(negedge clk); rst_b = 1'b0;
        @(posedge clk); #1 rst_b = 1'b1;
        ping(0, 1160);
        check("b3_d0", 32'(d0_o), 20);
        check("b3_far", 32'(far_o), 0);
        check("b3_mo", 32'(mo_o), 0);

        // 6-bit instance: 100 cm saturates at 63
        sel = 2;
        @(posedge clk); #1 rst_c = 1'b1;
        ping(0, 5800);
        check("c1_d0", 32'(d0_o), 63);
        check("c1_far", 32'(far_o), 1);
        check("c1_mo", 32'(mo_o), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sr04_multi_ranger.md
Name: sr04_multi_ranger

Overview:
Parametrised successor to the single-channel HC-SR04 controller. Services N_CH ultrasonic sensors round-robin, one ping in flight at a time to avoid crosstalk. Each channel gets echo timeout detection, saturating cm conversion, first-order IIR smoothing and near/far window flags. Sits between the sensor pins and the fan motor control logic. Its motor_off output replaces the single-sensor motor-off signal.

Parameters:
CLK_HZ, 100_000_000, system clock frequency; CLK_HZ/1_000_000 must be an integer >= 2
N_CH, 2, number of sensor channels (1..8)
DIST_W, 12, distance width in cm
TRIG_US, 10, trigger pulse width in us
GAP_US, 60_000, idle gap between the end of one ping and the next trigger
TIMEOUT_US, 30_000, maximum wait for the echo rise, and maximum echo high time
US_PER_CM, 58, microseconds per cm of distance
AVG_SH, 2, IIR shift (0 means no filtering)
NEAR_CM, 7, near threshold (inclusive)
FAR_CM, 80, far threshold (inclusive)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
echo  in  N_CH  raw echo inputs, asynchronous to clk
trigger  out  N_CH  trigger outputs, at most one bit high at a time
distance  out  N_CH*DIST_W  filtered distance per channel; channel k occupies bits [k*DIST_W +: DIST_W]
sample_valid  out  1  one-cycle pulse when a channel's result is updated
sample_ch  out  3  channel index for the current sample_valid
timeout  out  N_CH  per-channel sticky flag: set when that channel's last ping timed out
near  out  N_CH  per-channel flag: distance <= NEAR_CM and timeout clear
far  out  N_CH  per-channel flag: distance >= FAR_CM and timeout clear
motor_off  out  1  OR over all channels of (near | far | timeout)

Behaviour:
- Reset (async, reset_n low): all outputs 0, FSM in IDLE, channel pointer 0, all IIR "primed" bits cleared.
- us tick: free-running divider, one-cycle pulse every CLK_HZ/1_000_000 clocks. All us timers advance only on the tick.
- Echo path: 2-FF synchroniser per channel, then rise/fall edge detect. Edge latency is 3 clk from the pin.
- FSM states:
  - IDLE: wait GAP_US ticks, then go to TRIG.
  - TRIG: trigger[ptr]=1 for TRIG_US ticks, then go to WAIT_RISE.
  - WAIT_RISE: on rise of echo[ptr], go to MEASURE. If TIMEOUT_US ticks elapse first, go to TMO.
  - MEASURE: a sub-counter counts us ticks; on reaching US_PER_CM it resets and the raw cm count increments. The raw cm count saturates at 2^DIST_W-1. On fall, go to UPDATE. If TIMEOUT_US ticks elapse, go to TMO.
  - UPDATE: one clk; filter, assert sample_valid, clear timeout[ptr], then go to NEXT.
  - TMO: one clk; set timeout[ptr], distance[ptr] holds its old value, assert sample_valid, then go to NEXT.
  - NEXT: ptr = (ptr==N_CH-1) ? 0 : ptr+1; clear all timers; go to IDLE.
- Filter:
  - If channel not primed: avg = raw and set primed.
  - Otherwise: avg = avg + ((raw - avg) >>> AVG_SH).
  - Subtraction is signed at DIST_W+1 bits with arithmetic shift; the result is clamped to 0..2^DIST_W-1.
- Echo edges on non-selected channels are ignored. A rise seen in MEASURE is ignored. A fall seen in WAIT_RISE is ignored.
- If echo[ptr] is already high when the FSM enters WAIT_RISE, no rise is detected and the channel times out. This is intended, since a stuck echo is a fault.
- near, far and motor_off are registered and update in the cycle after sample_valid.
- sample_ch is valid only while sample_valid is high; it holds its value otherwise.
- Reset mid-ping drops trigger within the reset assertion, without waiting for a clock edge.

Test Plan:
- N_CH=2, AVG_SH=0, reduced timings. Ch0 echo high 1160us -> distance[0]=20, sample_valid with sample_ch=0, near/far/motor_off=0. Ch1 pinged next, with trigger[1] high exactly TRIG_US us.
- Ch1 echo never rises -> after TIMEOUT_US: timeout[1]=1, distance[1] unchanged, motor_off=1. Next good ping on ch1 clears timeout[1].
- AVG_SH=2, ch0 raw samples 100, then 20 -> distance 100, then 80; far[0]=1 after the first sample and stays 1 after the second (80 >= FAR_CM).
- Echo pulse of 290us (5cm) -> near=1, motor_off=1. Echo held high beyond TIMEOUT_US -> timeout path taken and trigger sequencing continues to the next channel.
- DIST_W=6, echo pulse 100cm-equivalent -> distance saturates at 63, far=1.
- Pulse reset_n low during MEASURE -> all outputs 0 asynchronously. Restart from ch0 after GAP_US, with the first sample loaded unfiltered.
